decode_stage: RTL and testbench

RV32I decode stage. Sits directly downstream of the instruction fetcher and directly upstream of the execute stage.
- Owns the IF/ID pipeline register.
- Decodes the held instruction into register indices, a sign-extended immediate and control flags, including the branch flags the fetcher consumes.
- Generates the pipeline stall on load-use hazards and execute back-pressure.
- Turns a misprediction flush into bubbles.

---
 rtl/decode_stage.sv | 141 ++++++++++++++
 tb/tb_decode_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: owns the IF/ID register, decodes the held instruction,
// raises the fetch stall on load-use hazards / execute back-pressure and turns flushes into bubbles.
module decode_stage #(
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc,
   input  logic [31:0]      inst,
   input  logic             flush,
   input  logic             ex_ready,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_valid,
   output logic             valid,
   output logic [31:0]      dec_pc,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [31:0]      imm,
   output logic [3:0]       alu_op,
   output logic             is_branch,
   output logic             bcond,
   output logic             base_gpr,
   output logic             is_load,
   output logic             is_store,
   output logic             illegal,
   output logic             blocked,
   output logic [CNT_W-1:0] issue_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   logic        held_valid;
   logic [31:0] held_inst;
   logic [31:0] held_pc;

   logic [6:0]  opcode;
   logic        fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
   logic        legal, active, is_shift;
   logic        uses_rs1, uses_rs2, hazard;

   assign opcode = held_inst[6:0];

   always_comb begin
      fmt_r = 1'b0;
      fmt_i = 1'b0;
      fmt_s = 1'b0;
      fmt_b = 1'b0;
      fmt_u = 1'b0;
      fmt_j = 1'b0;
      case (opcode)
         OPC_OP:                                              fmt_r = 1'b1;
         OPC_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM:  fmt_i = 1'b1;
         OPC_STORE:                                           fmt_s = 1'b1;
         OPC_BRANCH:                                          fmt_b = 1'b1;
         OPC_LUI, OPC_AUIPC:                                  fmt_u = 1'b1;
         OPC_JAL:                                             fmt_j = 1'b1;
         default: ;
      endcase
   end

   assign legal    = fmt_r | fmt_i | fmt_s | fmt_b | fmt_u | fmt_j;
   assign uses_rs1 = fmt_r | fmt_i | fmt_s | fmt_b;
   assign uses_rs2 = fmt_r | fmt_s | fmt_b;

   assign dec_pc = held_pc;
   assign rs1    = uses_rs1 ? held_inst[19:15] : 5'd0;
   assign rs2    = uses_rs2 ? held_inst[24:20] : 5'd0;
   assign rd     = (fmt_r | fmt_i | fmt_u | fmt_j) ? held_inst[11:7] : 5'd0;

   always_comb begin
      imm = 32'd0;
      if (fmt_i)
         imm = {{20{held_inst[31]}}, held_inst[31:20]};
      else if (fmt_s)
         imm = {{20{held_inst[31]}}, held_inst[31:25], held_inst[11:7]};
      else if (fmt_b)
         imm = {{19{held_inst[31]}}, held_inst[31], held_inst[7], held_inst[30:25],
                held_inst[11:8], 1'b0};
      else if (fmt_u)
         imm = {held_inst[31:12], 12'd0};
      else if (fmt_j)
         imm = {{11{held_inst[31]}}, held_inst[31], held_inst[19:12], held_inst[20],
                held_inst[30:21], 1'b0};
   end

   // funct7[5] only distinguishes sub/sra/srai; elsewhere bit 30 is immediate data
   assign is_shift = (opcode == OPC_IMM) && (held_inst[13:12] == 2'b01);
   assign alu_op   = {(fmt_r | is_shift) & held_inst[30], held_inst[14:12]};

   assign active    = held_valid & legal;
   assign illegal   = held_valid & ~legal;
   assign is_branch = active & ((opcode == OPC_JAL) | (opcode == OPC_JALR) | (opcode == OPC_BRANCH));
   assign bcond     = active & (opcode == OPC_BRANCH);
   assign base_gpr  = active & (opcode == OPC_JALR);
   assign is_load   = active & (opcode == OPC_LOAD);
   assign is_store  = active & (opcode == OPC_STORE);

   assign hazard  = held_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));
   // a flush discards the held instruction, so it must never also stall fetch
   assign blocked = held_valid & (hazard | ~ex_ready) & ~flush;
   assign valid   = held_valid & ~illegal & ~blocked & ~flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         held_valid <= 1'b0;
         held_inst  <= NOP_INST;
         held_pc    <= 32'd0;
         issue_cnt  <= '0;
         stall_cnt  <= '0;
      end else begin
         if (valid)
            issue_cnt <= issue_cnt + CNT_W'(1);
         if (blocked)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush) begin
            held_valid <= 1'b0;
            held_inst  <= NOP_INST;
         end else if (!blocked) begin
            held_valid <= 1'b1;
            held_inst  <= inst;
            held_pc    <= pc;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a behavioural model predicts issues and per-cycle
// status, a negedge monitor compares whatever the DUT presents.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset, flush, ex_ready, ex_is_load, ex_valid;
   logic [31:0] pc, inst;
   logic [4:0]  ex_rd;
   logic        valid, is_branch, bcond, base_gpr, is_load, is_store, illegal, blocked;
   logic [31:0] dec_pc, imm, issue_cnt, stall_cnt;
   logic [4:0]  rs1, rs2, rd;
   logic [3:0]  alu_op;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .reset(reset), .pc(pc), .inst(inst), .flush(flush), .ex_ready(ex_ready),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_valid(ex_valid), .valid(valid),
      .dec_pc(dec_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
      .is_branch(is_branch), .bcond(bcond), .base_gpr(base_gpr), .is_load(is_load),
      .is_store(is_store), .illegal(illegal), .blocked(blocked),
      .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic        legal, u1, u2;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic        br, bc, bg, ld, st;
   } dec_t;

   typedef struct {
      logic [31:0] pc;
      dec_t        d;
   } issue_t;

   typedef struct {
      logic        valid, blocked, illegal;
      logic [31:0] issue, stall;
   } cyc_t;

   issue_t issq[$];
   cyc_t   cycq[$];

   // model state
   logic        m_known = 1'b0;
   logic        m_valid;
   logic [31:0] m_inst, m_pc, m_issue, m_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Decode from the ISA tables: instruction format first, then field extraction by arithmetic.
   function automatic dec_t ref_decode(input logic [31:0] w);
      dec_t d;
      byte  fmt;
      int   v;
      logic shift;
      case (w[6:0])
         7'h33:                             fmt = "R";
         7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: fmt = "I";
         7'h23:                             fmt = "S";
         7'h63:                             fmt = "B";
         7'h37, 7'h17:                      fmt = "U";
         7'h6F:                             fmt = "J";
         default:                           fmt = "X";
      endcase
      d.legal = (fmt != "X");
      d.u1  = (fmt == "R") || (fmt == "I") || (fmt == "S") || (fmt == "B");
      d.u2  = (fmt == "R") || (fmt == "S") || (fmt == "B");
      d.rs1 = d.u1 ? w[19:15] : 5'd0;
      d.rs2 = d.u2 ? w[24:20] : 5'd0;
      d.rd  = ((fmt == "R") || (fmt == "I") || (fmt == "U") || (fmt == "J")) ? w[11:7] : 5'd0;
      v = 0;
      case (fmt)
         "I": begin v = int'(w[31:20]); if (v >= 2048) v -= 4096; end
         "S": begin v = int'(w[31:25]) * 32 + int'(w[11:7]); if (v >= 2048) v -= 4096; end
         "B": begin
            v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            if (w[31]) v -= 8192;
         end
         "J": begin
            v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                + int'(w[30:21]) * 2;
            if (w[31]) v -= (1 << 21);
         end
         default: v = 0;
      endcase
      d.imm = (fmt == "U") ? (w & 32'hFFFFF000) : 32'(v);
      shift = (w[6:0] == 7'h13) && ((w[14:12] == 3'd1) || (w[14:12] == 3'd5));
      d.alu_op = {((fmt == "R") || shift) ? w[30] : 1'b0, w[14:12]};
      d.br = d.legal && ((w[6:0] == 7'h6F) || (w[6:0] == 7'h67) || (w[6:0] == 7'h63));
      d.bc = d.legal && (w[6:0] == 7'h63);
      d.bg = d.legal && (w[6:0] == 7'h67);
      d.ld = d.legal && (w[6:0] == 7'h03);
      d.st = d.legal && (w[6:0] == 7'h23);
      return d;
   endfunction

   // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
   task automatic step(input logic r, input logic [31:0] p, input logic [31:0] i,
                       input logic f, input logic rdy, input logic [4:0] erd,
                       input logic eld, input logic evl);
      dec_t   d;
      cyc_t   c;
      issue_t is;
      logic   haz, blk, vld, ill;
      @(posedge clk);
      #1;
      reset = r; pc = p; inst = i; flush = f; ex_ready = rdy;
      ex_rd = erd; ex_is_load = eld; ex_valid = evl;
      if (m_known) begin
         d   = ref_decode(m_inst);
         ill = m_valid && !d.legal;
         haz = m_valid && evl && eld && (erd != 0) &&
               ((d.u1 && d.rs1 == erd) || (d.u2 && d.rs2 == erd));
         blk = m_valid && (haz || !rdy) && !f;
         vld = m_valid && !ill && !blk && !f;
         c.valid = vld; c.blocked = blk; c.illegal = ill;
         c.issue = m_issue; c.stall = m_stall;
         cycq.push_back(c);
         if (vld) begin
            is.pc = m_pc;
            is.d  = d;
            issq.push_back(is);
         end
         if (!r) begin
            m_issue += vld ? 1 : 0;
            m_stall += blk ? 1 : 0;
            if (f) begin
               m_valid = 1'b0;
               m_inst  = 32'h00000013;
            end else if (!blk) begin
               m_valid = 1'b1;
               m_inst  = i;
               m_pc    = p;
            end
         end
      end
      if (r) begin
         m_known = 1'b1;
         m_valid = 1'b0;
         m_inst  = 32'h00000013;
         m_pc    = 32'd0;
         m_issue = 32'd0;
         m_stall = 32'd0;
      end
   endtask

   always @(negedge clk) begin
      cyc_t   c;
      issue_t e;
      if (cycq.size() > 0) begin
         c = cycq.pop_front();
         chk("valid", 32'(valid), 32'(c.valid));
         chk("blocked", 32'(blocked), 32'(c.blocked));
         chk("illegal", 32'(illegal), 32'(c.illegal));
         chk("issue_cnt", issue_cnt, c.issue);
         chk("stall_cnt", stall_cnt, c.stall);
      end
      if (valid === 1'b1) begin
         if (issq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got pc %h inst issued, expected none", dec_pc);
         end else begin
            e = issq.pop_front();
            chk("pc", dec_pc, e.pc);
            chk("rs1", 32'(rs1), 32'(e.d.rs1));
            chk("rs2", 32'(rs2), 32'(e.d.rs2));
            chk("rd", 32'(rd), 32'(e.d.rd));
            chk("imm", imm, e.d.imm);
            chk("alu_op", 32'(alu_op), 32'(e.d.alu_op));
            chk("flags", 32'({is_branch, bcond, base_gpr, is_load, is_store}),
                32'({e.d.br, e.d.bc, e.d.bg, e.d.ld, e.d.st}));
         end
      end
   end

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73,
                                7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
      logic [31:0] w = $urandom;
      w[6:0]   = ops[$urandom_range(0, 11)];
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      return w;
   endfunction

   localparam logic [31:0] ADDI = 32'h00500093, BEQ = 32'hFE208CE3, ADD = 32'h00028333;
   localparam logic [31:0] JALR = 32'h00008067, LUI = 32'h123451B7, BAD = 32'h0000007F;
   localparam logic [31:0] WRONG = 32'h06300513;

   initial begin
      reset = 1'b1; pc = '0; inst = '0; flush = 1'b0; ex_ready = 1'b1;
      ex_rd = '0; ex_is_load = 1'b0; ex_valid = 1'b0;

      step(1, 0, 0, 0, 1, 0, 0, 0);
      step(0, 32'h0, ADDI, 0, 1, 0, 0, 0);
      @(negedge clk); chk("reset_valid", 32'(valid), 0); chk("reset_issue_cnt", issue_cnt, 0);
      step(0, 32'h100, BEQ, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("addi_valid", 32'(valid), 1); chk("addi_rd", 32'(rd), 1);
      chk("addi_rs1", 32'(rs1), 0); chk("addi_imm", imm, 32'h5);
      chk("addi_branch", 32'(is_branch), 0);
      step(0, 32'h104, ADD, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("beq_pc", dec_pc, 32'h100); chk("beq_bcond", 32'(bcond), 1);
      chk("beq_branch", 32'(is_branch), 1); chk("beq_base", 32'(base_gpr), 0);
      chk("beq_imm", imm, 32'hFFFFFFF8); chk("beq_rs1", 32'(rs1), 1); chk("beq_rs2", 32'(rs2), 2);
      chk("addi_issue_cnt", issue_cnt, 1);
      step(0, 32'h108, JALR, 0, 1, 5, 1, 1);
      @(negedge clk);
      chk("lu_blocked", 32'(blocked), 1); chk("lu_valid", 32'(valid), 0);
      step(0, 32'h108, JALR, 0, 1, 5, 0, 1);
      @(negedge clk);
      chk("lu_release_valid", 32'(valid), 1); chk("lu_release_rd", 32'(rd), 6);
      chk("lu_stall_cnt", stall_cnt, 1);
      step(0, 32'h10C, LUI, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("jalr_branch", 32'(is_branch), 1); chk("jalr_base", 32'(base_gpr), 1);
      chk("jalr_bcond", 32'(bcond), 0); chk("jalr_imm", imm, 0);
      step(0, 32'h110, ADDI, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("lui_imm", imm, 32'h12345000); chk("lui_rd", 32'(rd), 3); chk("lui_rs1", 32'(rs1), 0);
      step(0, 32'h114, WRONG, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("flush_valid", 32'(valid), 0); chk("flush_blocked", 32'(blocked), 0);
      step(0, 32'h200, BAD, 0, 1, 0, 0, 0);
      @(negedge clk); chk("post_flush_valid", 32'(valid), 0);
      step(0, 32'h204, ADD, 0, 1, 5, 1, 1);
      @(negedge clk);
      chk("illegal_flag", 32'(illegal), 1); chk("illegal_valid", 32'(valid), 0);
      chk("illegal_issue_cnt", issue_cnt, 5);
      step(0, 32'h208, ADDI, 0, 1, 5, 1, 1);
      @(negedge clk); chk("stall_before_reset", 32'(blocked), 1);
      step(1, 32'h208, ADDI, 0, 1, 5, 1, 1);
      step(0, 32'h0, 32'h00000013, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("rst_stall_valid", 32'(valid), 0); chk("rst_issue_cnt", issue_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);

      for (int n = 0; n < 4000; n++)
         step($urandom_range(0, 99) < 2, $urandom & 32'hFFFFFFFC, rand_inst(),
              $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 80,
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 99) < 70);

      step(0, 0, 32'h00000013, 1, 1, 0, 0, 0);
      @(negedge clk);
      @(posedge clk);
      chk("issue_queue_drained", 32'(issq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
